// File: rtl/seq_pattern_tx_if.sv
// Request/serial-output bundle for seq_pattern_tx: the requester drives start and
// the pattern fields, and the transmitter drives the serial line and status.
interface seq_pattern_tx_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 4
) ();

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] nbits;
  logic [CNT_W-1:0] reps;
  logic             x;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, nbits, reps,
    input  x, valid, busy, done
  );

  modport slave (
    input  start, pattern, nbits, reps,
    output x, valid, busy, done
  );

endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeated reps
// times with GAP idle cycles between repetitions. Every output is registered.
module seq_pattern_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic           clk,
  input  logic           rst,
  seq_pattern_tx_if.slave bus
);

  // One spare bit so the gap counter is at least 1 bit wide even when GAP is 0.
  localparam int unsigned GapW = $clog2(GAP + 1) + 1;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap,
    StDone
  } state_e;

  state_e           state;
  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] shift_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bit_q;
  logic [CNT_W-1:0] rep_q;
  logic [GapW-1:0]  gap_q;
  logic             x_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic [LEN_W-1:0] nbits_clamp;

  always_comb begin
    nbits_clamp = bus.nbits;
    if (bus.nbits > LEN_W'(WIDTH)) begin
      nbits_clamp = LEN_W'(WIDTH);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StIdle;
      pat_q   <= '0;
      shift_q <= '0;
      len_q   <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.start) begin
            pat_q   <= bus.pattern;
            shift_q <= bus.pattern;
            len_q   <= nbits_clamp;
            bit_q   <= nbits_clamp;
            rep_q   <= bus.reps;
            if (nbits_clamp == '0 || bus.reps == '0) begin
              state <= StDone;
            end else begin
              state <= StSend;
            end
          end
        end
        StSend: begin
          x_q     <= shift_q[WIDTH-1];
          valid_q <= 1'b1;
          busy_q  <= 1'b1;
          shift_q <= shift_q << 1;
          bit_q   <= bit_q - LEN_W'(1);
          if (bit_q == LEN_W'(1)) begin
            if (rep_q > CNT_W'(1)) begin
              rep_q <= rep_q - CNT_W'(1);
              if (GAP > 0) begin
                gap_q <= GapW'(GAP);
                state <= StGap;
              end else begin
                // Back-to-back: reload now so the next bit follows with no bubble.
                shift_q <= pat_q;
                bit_q   <= len_q;
              end
            end else begin
              state <= StDone;
            end
          end
        end
        StGap: begin
          busy_q <= 1'b1;
          gap_q  <= gap_q - GapW'(1);
          if (gap_q == GapW'(1)) begin
            shift_q <= pat_q;
            bit_q   <= len_q;
            state   <= StSend;
          end
        end
        StDone: begin
          done_q <= 1'b1;
          state  <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.x     = x_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: one instance with GAP=1 and one with GAP=0,
// each compared cycle by cycle against expected {x,valid,busy,done} queues.
module tb_seq_pattern_tx;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_pattern_tx_if #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) if_g1 ();
  seq_pattern_tx_if #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) if_g0 ();

  seq_pattern_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP(1)) dut_g1 (
    .clk (clk),
    .rst (rst),
    .bus (if_g1.slave)
  );

  seq_pattern_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP(0)) dut_g0 (
    .clk (clk),
    .rst (rst),
    .bus (if_g0.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_g1[$];
  logic [3:0] exp_g0[$];
  logic [3:0] e1, e0;
  bit mon_en = 1'b0;
  int vcnt_g1, vcnt_g0, dcnt_g1, run_g0, max_run_g0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Idle (empty queue) means every output must be 0.
  always @(negedge clk) begin
    if (mon_en) begin
      e1 = (exp_g1.size() != 0) ? exp_g1.pop_front() : 4'b0000;
      e0 = (exp_g0.size() != 0) ? exp_g0.pop_front() : 4'b0000;
      check_eq("g1_out", {28'd0, if_g1.x, if_g1.valid, if_g1.busy, if_g1.done}, {28'd0, e1});
      check_eq("g0_out", {28'd0, if_g0.x, if_g0.valid, if_g0.busy, if_g0.done}, {28'd0, e0});
      if (if_g1.valid) vcnt_g1++;
      if (if_g0.valid) vcnt_g0++;
      if (if_g1.done) dcnt_g1++;
      if (if_g0.valid && if_g0.x) begin
        run_g0++;
        if (run_g0 > max_run_g0) max_run_g0 = run_g0;
      end else begin
        run_g0 = 0;
      end
    end
  end

  task automatic expect_xfer(input bit use_g1, input logic [WIDTH-1:0] pat, input int nbits,
                             input int reps);
    logic [3:0] v[$];
    int nb;
    int gap;
    gap = use_g1 ? 1 : 0;
    nb = (nbits > int'(WIDTH)) ? int'(WIDTH) : nbits;
    v.push_back(4'b0000);
    if (nb != 0 && reps != 0) begin
      for (int r = 0; r < reps; r++) begin
        for (int i = 0; i < nb; i++) v.push_back({pat[WIDTH-1-i], 3'b110});
        if (r < reps - 1) for (int g = 0; g < gap; g++) v.push_back(4'b0010);
      end
    end
    v.push_back(4'b0001);
    foreach (v[k]) begin
      if (use_g1) exp_g1.push_back(v[k]);
      else exp_g0.push_back(v[k]);
    end
  endtask

  task automatic start_xfer(input bit use_g1, input logic [WIDTH-1:0] pat, input int nbits,
                            input int reps);
    @(negedge clk);
    #1;
    if (use_g1) begin
      if_g1.pattern = pat;
      if_g1.nbits   = LEN_W'(nbits);
      if_g1.reps    = CNT_W'(reps);
      if_g1.start   = 1'b1;
    end else begin
      if_g0.pattern = pat;
      if_g0.nbits   = LEN_W'(nbits);
      if_g0.reps    = CNT_W'(reps);
      if_g0.start   = 1'b1;
    end
    expect_xfer(use_g1, pat, nbits, reps);
    @(posedge clk);
    #1;
    if_g1.start = 1'b0;
    if_g0.start = 1'b0;
  endtask

  task automatic wait_drain();
    bit drained;
    drained = 1'b0;
    for (int c = 0; c < 300 && !drained; c++) begin
      @(negedge clk);
      #2;
      drained = (exp_g1.size() == 0) && (exp_g0.size() == 0);
    end
    check_eq("drain", {31'd0, drained}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_counts();
    vcnt_g1 = 0;
    vcnt_g0 = 0;
    dcnt_g1 = 0;
    max_run_g0 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {if_g1.start, if_g1.pattern, if_g1.nbits, if_g1.reps} = '0;
    {if_g0.start, if_g0.pattern, if_g0.nbits, if_g0.reps} = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_g1", {28'd0, if_g1.x, if_g1.valid, if_g1.busy, if_g1.done}, 32'd0);
    check_eq("rst_g0", {28'd0, if_g0.x, if_g0.valid, if_g0.busy, if_g0.done}, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Single burst.
    clear_counts();
    start_xfer(1'b1, 8'b1110_0000, 3, 1);
    wait_drain();
    check_eq("burst_valid", vcnt_g1, 3);

    // Repeat with one gap cycle.
    clear_counts();
    start_xfer(1'b1, 8'b1011_0000, 4, 2);
    wait_drain();
    check_eq("gap_valid", vcnt_g1, 8);

    // Back-to-back: six consecutive ones.
    clear_counts();
    start_xfer(1'b0, 8'hE0, 3, 2);
    wait_drain();
    check_eq("b2b_run", max_run_g0, 6);

    // Clamp and degenerate cases.
    clear_counts();
    start_xfer(1'b1, 8'hA5, 15, 1);
    wait_drain();
    check_eq("clamp_valid", vcnt_g1, 8);
    clear_counts();
    start_xfer(1'b0, 8'hFF, 0, 3);
    start_xfer(1'b1, 8'hFF, 5, 0);
    wait_drain();
    check_eq("degen_valid", vcnt_g1 + vcnt_g0, 0);

    // Maximum repetition count, back-to-back.
    clear_counts();
    start_xfer(1'b0, 8'h80, 2, 15);
    wait_drain();
    check_eq("maxreps_valid", vcnt_g0, 30);

    // Start ignored while busy and while in DONE; live pattern changes ignored.
    clear_counts();
    start_xfer(1'b1, 8'b1010_0000, 3, 1);
    @(posedge clk);
    #1;
    if_g1.start = 1'b1;
    if_g1.pattern = 8'hFF;
    @(posedge clk);
    #1;
    if_g1.start = 1'b0;
    @(posedge clk);
    #1;
    if_g1.start = 1'b1;
    @(posedge clk);
    #1;
    if_g1.start = 1'b0;
    wait_drain();
    check_eq("ignored_done", dcnt_g1, 1);

    // Asynchronous reset mid-SEND.
    clear_counts();
    start_xfer(1'b1, 8'hFF, 8, 3);
    repeat (3) @(posedge clk);
    #3;
    check_eq("pre_rst_busy", {31'd0, if_g1.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("async_rst", {28'd0, if_g1.x, if_g1.valid, if_g1.busy, if_g1.done}, 32'd0);
    exp_g1.delete();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("rst_no_done", dcnt_g1, 0);
    start_xfer(1'b1, 8'hE0, 3, 1);
    wait_drain();
    check_eq("post_rst_done", dcnt_g1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
